// File: rtl/path_chk_pkg.sv
// path_chk_pkg: shared FSM state, default bus addresses and node type for the path node checker
package path_chk_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  localparam logic [31:0] NODE_ADDR_DEF = 32'h0200_0008;
  localparam logic [31:0] DONE_ADDR_DEF = 32'h0200_000C;
  localparam int NODE_W_DEF = 5;
  typedef logic [NODE_W_DEF-1:0] node_t;
endpackage

// File: rtl/path_node_table.sv
// path_node_table: W x DEPTH table, one sync write port (clk,we,wa,wd), one combinational read port (ra->rd)
module path_node_table
  import path_chk_pkg::*;
#(
  parameter int W = NODE_W_DEF,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/path_node_checker.sv
// path_node_checker: snoops CPU stores (MemWrite/DataAdr/WriteData), checks NODE_POINT writes against a loaded path (load_*), reports node_idx/exp_len/mismatch/error_count/done/pass/load_ovf; PATH_CHECK_CAPTURE_EN adds capture RAM with cap_rd_idx/cap_rd_node readback
module path_node_checker
  import path_chk_pkg::*;
#(
  parameter int NODE_W = NODE_W_DEF,
  parameter int MAX_NODES = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] NODE_ADDR = ADDR_W'(NODE_ADDR_DEF),
  parameter logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(DONE_ADDR_DEF),
  parameter int ERR_W = 8,
  localparam int AW = $clog2(MAX_NODES),
  localparam int IW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [NODE_W-1:0] load_node,
  input  logic              load_last,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [31:0]       WriteData,
  output logic [IW-1:0]     node_idx,
  output logic [IW-1:0]     exp_len,
  output logic              mismatch,
  output logic [ERR_W-1:0]  error_count,
  output logic              done,
  output logic              pass,
  output logic              load_ovf
`ifdef PATH_CHECK_CAPTURE_EN
  ,
  input  logic [AW-1:0]     cap_rd_idx,
  output logic [NODE_W-1:0] cap_rd_node
`endif
);
  localparam logic [IW-1:0] MAXN = IW'(MAX_NODES);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_t state;
  logic [NODE_W-1:0] exp_node;
  logic node_wr, done_wr, node_err;
  logic [IW-1:0] missing, inc;
  logic [31:0] sum;
  logic [ERR_W-1:0] err_next;
  always_comb begin
    node_wr = state == RUN && MemWrite && DataAdr == NODE_ADDR;
    done_wr = state == RUN && MemWrite && DataAdr == DONE_ADDR && WriteData == 32'd1;
    node_err = exp_node != WriteData[NODE_W-1:0] || |WriteData[31:NODE_W] || node_idx >= exp_len;
    missing = node_idx < exp_len ? exp_len - node_idx : '0;
    inc = node_wr ? IW'(node_err) : done_wr ? missing : '0;
    sum = 32'(error_count) + 32'(inc);
    err_next = sum > 32'(ERR_MAX) ? ERR_MAX : sum[ERR_W-1:0];
  end
  path_node_table #(.W(NODE_W), .DEPTH(MAX_NODES)) u_table (
    .clk(clk),
    .we(state == LOAD && load_valid && exp_len != MAXN),
    .wa(exp_len[AW-1:0]),
    .wd(load_node),
    .ra(node_idx[AW-1:0]),
    .rd(exp_node)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      node_idx <= '0;
      exp_len <= '0;
      mismatch <= 1'b0;
      error_count <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      load_ovf <= 1'b0;
    end else begin
      mismatch <= node_wr && node_err;
      if (state == LOAD && load_valid) begin
        if (exp_len == MAXN) load_ovf <= 1'b1;
        else exp_len <= exp_len + 1'b1;
        if (load_last) state <= RUN;
      end
      if (state == RUN) error_count <= err_next;
      if (node_wr && node_idx != MAXN) node_idx <= node_idx + 1'b1;
      if (done_wr) begin
        state <= DONE;
        done <= 1'b1;
        pass <= error_count == '0 && node_idx == exp_len && exp_len != '0;
      end
    end
  end
`ifdef PATH_CHECK_CAPTURE_EN
  logic [NODE_W-1:0] cap_q;
  path_node_table #(.W(NODE_W), .DEPTH(MAX_NODES)) u_cap (
    .clk(clk),
    .we(node_wr && node_idx != MAXN),
    .wa(node_idx[AW-1:0]),
    .wd(WriteData[NODE_W-1:0]),
    .ra(cap_rd_idx),
    .rd(cap_q)
  );
  always_ff @(posedge clk) cap_rd_node <= reset ? '0 : cap_q;
`endif
endmodule

// File: tb/tb_path_node_checker.sv
// tb_path_node_checker: random and directed stimulus checked every cycle against a queue-based path model
module tb_path_node_checker;
  import path_chk_pkg::*;
  localparam int MAXN = 32;
  localparam int EMAX = 255;
  localparam logic [31:0] NA = 32'h0200_0008;
  localparam logic [31:0] DA = 32'h0200_000C;
  logic clk = 0, reset = 1, load_valid = 0, load_last = 0, MemWrite = 0;
  node_t load_node = '0;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic [5:0] node_idx, exp_len;
  logic mismatch, done, pass, load_ovf;
  logic [7:0] error_count;
`ifdef PATH_CHECK_CAPTURE_EN
  logic [4:0] cap_rd_idx = '0;
  logic [4:0] cap_rd_node;
`endif
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int m_st = 0, m_idx = 0, m_err = 0;
  bit m_mis = 0, m_done = 0, m_pass = 0, m_ovf = 0;
  int m_tab[$];
  path_node_checker dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_node(load_node), .load_last(load_last),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .node_idx(node_idx), .exp_len(exp_len), .mismatch(mismatch), .error_count(error_count),
    .done(done), .pass(pass), .load_ovf(load_ovf)
`ifdef PATH_CHECK_CAPTURE_EN
    , .cap_rd_idx(cap_rd_idx), .cap_rd_node(cap_rd_node)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    bit bad;
    m_mis = 0;
    if (reset) begin
      m_st = 0; m_idx = 0; m_err = 0; m_done = 0; m_pass = 0; m_ovf = 0;
      m_tab.delete();
    end else if (m_st == 0) begin
      if (load_valid) begin
        if (m_tab.size() < MAXN) m_tab.push_back(int'(load_node));
        else m_ovf = 1;
        if (load_last) m_st = 1;
      end
    end else if (m_st == 1 && MemWrite) begin
      if (DataAdr == NA) begin
        bad = m_idx >= m_tab.size();
        if (!bad) bad = WriteData != 32'(m_tab[m_idx]);
        if (bad) begin
          m_mis = 1;
          m_err++;
        end
        if (m_idx < MAXN) m_idx++;
      end else if (DataAdr == DA && WriteData == 1) begin
        if (m_idx < m_tab.size()) m_err += m_tab.size() - m_idx;
        m_done = 1;
        m_st = 2;
        m_pass = m_err == 0 && m_idx == m_tab.size() && m_tab.size() != 0;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("node_idx", 32'(node_idx), 32'(m_idx));
    chk("exp_len", 32'(exp_len), 32'(m_tab.size()));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("error_count", 32'(error_count), 32'(m_err > EMAX ? EMAX : m_err));
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("load_ovf", 32'(load_ovf), 32'(m_ovf));
  end
  task automatic drive(input logic lv, input node_t ln, input logic ll, input logic mw,
                       input logic [31:0] adr, input logic [31:0] wd, input logic rst);
    @(negedge clk);
    load_valid = lv; load_node = ln; load_last = ll;
    MemWrite = mw; DataAdr = adr; WriteData = wd; reset = rst;
  endtask
  task automatic idle();
    drive(0, '0, 0, 0, '0, '0, 0);
  endtask
  task automatic do_reset();
    drive(0, '0, 0, 0, '0, '0, 1);
    idle();
  endtask
  task automatic load_path(input int vals[$]);
    foreach (vals[i]) drive(1, node_t'(vals[i]), i == vals.size() - 1, 0, '0, '0, 0);
    idle();
  endtask
  task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
    drive(0, '0, 0, 1, adr, wd, 0);
  endtask
  initial begin
    int len, r, want;
    int big[$];
    repeat (2) @(negedge clk);
    do_reset();
    chk_en = 1;
    chk("rst_node_idx", 32'(node_idx), 0);
    chk("rst_error_count", 32'(error_count), 0);
    chk("rst_done", 32'(done), 0);
    load_path('{3, 7, 12, 20});
    wr(NA, 3); wr(NA, 7); wr(NA, 12); wr(NA, 20); wr(DA, 1); idle();
    chk("t1_error_count", 32'(error_count), 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_node_idx", 32'(node_idx), 4);
    do_reset();
    load_path('{3, 7, 12, 20});
    wr(NA, 3); wr(NA, 8); idle();
    chk("t2_mismatch_pulse", 32'(mismatch), 1);
    chk("t2_error_count", 32'(error_count), 1);
    idle();
    chk("t2_mismatch_end", 32'(mismatch), 0);
    wr(NA, 12); wr(NA, 20); wr(DA, 1); idle();
    chk("t2_pass", 32'(pass), 0);
    do_reset();
    load_path('{1, 2, 3, 4});
    wr(NA, 1); wr(NA, 2); wr(DA, 1); idle();
    chk("t3_missing_errors", 32'(error_count), 2);
    chk("t3_pass", 32'(pass), 0);
    do_reset();
    load_path('{1, 2, 3, 4});
    wr(NA, 1); wr(NA, 2); wr(NA, 3); wr(NA, 4); wr(NA, 9); idle();
    chk("t3_extra_errors", 32'(error_count), 1);
    chk("t3_extra_idx", 32'(node_idx), 5);
    do_reset();
    for (int i = 0; i < MAXN + 2; i++) big.push_back(i % 32);
    load_path(big);
    chk("t4_load_ovf", 32'(load_ovf), 1);
    chk("t4_exp_len", 32'(exp_len), 32);
    wr(NA, 0); wr(NA, 1); idle();
    do_reset();
    chk("t4_rst_exp_len", 32'(exp_len), 0);
    chk("t4_rst_load_ovf", 32'(load_ovf), 0);
    chk("t4_rst_node_idx", 32'(node_idx), 0);
    load_path('{3});
    wr(NA, 32'h23); idle();
    chk("t5_upper_bits", 32'(error_count), 1);
    wr(DA, 2); idle();
    chk("t5_done_ignored", 32'(done), 0);
    do_reset();
    load_path('{0});
    repeat (300) wr(NA, 1);
    idle();
    chk("t6_err_saturate", 32'(error_count), 255);
    chk("t6_idx_saturate", 32'(node_idx), 32);
`ifdef PATH_CHECK_CAPTURE_EN
    do_reset();
    load_path('{3, 7, 12});
    wr(NA, 3); wr(NA, 7); wr(NA, 12); idle();
    cap_rd_idx = 1;
    @(negedge clk);
    chk("cap_rd_node", 32'(cap_rd_node), 7);
`endif
    for (int run = 0; run < 40; run++) begin
      do_reset();
      len = $urandom_range(1, MAXN + 3);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) wr(NA, $urandom_range(0, 31));
        drive(1, node_t'($urandom_range(0, 31)), i == len - 1, 0, '0, '0, 0);
      end
      for (int c = 0; c < 80; c++) begin
        r = $urandom_range(0, 99);
        want = m_idx < m_tab.size() ? m_tab[m_idx] : $urandom_range(0, 31);
        if (r < 45) wr(NA, 32'(want));
        else if (r < 55) wr(NA, $urandom_range(0, 31));
        else if (r < 60) wr(NA, $urandom);
        else if (r < 65) wr(DA, $urandom_range(2, 5));
        else if (r < 68) wr(DA, 1);
        else if (r < 75) wr($urandom, $urandom);
        else if (r < 77) drive(0, '0, 0, 0, '0, '0, 1);
        else idle();
      end
    end
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
